memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/caches_pkg.sv | 17 +
 rtl/memory_arbiter.sv | 148 ++++++++++++++
 tb/tb_memory_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/caches_pkg.sv
// Shared types for the cache-side memory arbiter: FSM states, grant side, default timeout.
package caches_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam int MAX_WAIT_DEFAULT = 255;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one RAM port; define MEMORY_ARBITER_RR_EN for round-robin ties.
// Latency: request seen in IDLE, granted next cycle, wait drops in the first grant cycle with ramready (min 2 cycles).
// Backpressure: requesters hold until their wait drops; a grant with no ramready for MAX_WAIT cycles times out and sets err.
module memory_arbiter
    import caches_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic dreq;
    logic held;
    logic pick_d;

    assign dreq = dREN | dWEN;

`ifdef MEMORY_ARBITER_RR_EN
    grant_t last_q, last_d;

    // On a tie, serve whichever side lost the previous grant.
    assign pick_d = dreq & (~iREN | (last_q == GRANT_I));

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (dreq || iREN)) begin
            last_d = pick_d ? GRANT_D : GRANT_I;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_q <= GRANT_D;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick_d = dreq;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        iwait   = 1'b1;
        dwait   = 1'b1;
        held    = (state_q == IGRANT) ? iREN : dreq;

        case (state_q)
            IDLE: begin
                if (dreq || iREN) begin
                    cnt_d = '0;
                    if (pick_d) begin
                        state_d = DGRANT;
                        addr_d  = daddr;
                        store_d = dstore;
                        wr_d    = dWEN;
                    end else begin
                        state_d = IGRANT;
                        addr_d  = iaddr;
                        store_d = '0;
                        wr_d    = 1'b0;
                    end
                end
            end
            IGRANT, DGRANT: begin
                // A withdrawn request ends the grant silently, even if ramready arrives now.
                if (!held) begin
                    state_d = IDLE;
                end else if (ramready) begin
                    state_d = IDLE;
                    if (state_q == IGRANT) begin
                        iwait = 1'b0;
                    end else begin
                        dwait = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ramREN   = (state_q == IGRANT) | ((state_q == DGRANT) & ~wr_q);
    assign ramWEN   = (state_q == DGRANT) & wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iload    = ramload;
    assign dload    = ramload;
    assign err      = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed table, corner sequences, randomized run against a reference model.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {iwait, dwait, ramREN, ramWEN, err}
    function automatic logic [31:0] ctrl();
        return {27'd0, iwait, dwait, ramREN, ramWEN, err};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_ctrl", ctrl(), 32'b11000);
        chk("reset_addr", ramaddr, 32'h0);
        nRST = 1;
    endtask

    // ---------------- reference model (transaction view) ----------------
    int          m_side;      // 0 none, 1 instruction, 2 data
    int          m_last;      // side served by the most recent grant
    int          m_waited;    // cycles of this grant spent without ramready
    bit          m_wr, m_err;
    logic [31:0] m_addr, m_store;
    logic        e_iwait, e_dwait, e_ren, e_wen;

    task automatic model_reset();
        m_side = 0; m_last = 2; m_waited = 0; m_wr = 0; m_err = 0;
        m_addr = 0; m_store = 0;
    endtask

    function automatic bit m_held();
        if (m_side == 1) return iREN;
        if (m_side == 2) return dREN | dWEN;
        return 0;
    endfunction

    task automatic model_expect();
        e_ren   = (m_side == 1) || (m_side == 2 && !m_wr);
        e_wen   = (m_side == 2) && m_wr;
        e_iwait = !(m_side == 1 && m_held() && ramready);
        e_dwait = !(m_side == 2 && m_held() && ramready);
    endtask

    task automatic model_advance();
        int pick;
        if (m_side == 0) begin
            pick = 0;
            if ((dREN | dWEN) && iREN) begin
`ifdef MEMORY_ARBITER_RR_EN
                pick = (m_last == 1) ? 2 : 1;
`else
                pick = 2;
`endif
            end else if (dREN | dWEN) pick = 2;
            else if (iREN) pick = 1;
            if (pick != 0) begin
                m_side = pick; m_last = pick; m_waited = 0;
                if (pick == 1) begin
                    m_addr = iaddr; m_store = 0; m_wr = 0;
                end else begin
                    m_addr = daddr; m_store = dstore; m_wr = dWEN;
                end
            end
        end else if (!m_held() || ramready) begin
            m_side = 0;
        end else begin
            m_waited++;
            if (m_waited == 255) begin
                m_side = 0;
                m_err  = 1;
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        iren, dren, dwen, rr;
        logic [31:0] ia, da, ds, rl;
        logic [31:0] ectrl;
        logic        ca;
        logic [31:0] ea;
        logic        cs;
        logic [31:0] es;
    } vec_t;

    vec_t tv[15];

    task automatic fill_table();
        //          iren dren dwen rr  ia      da      ds            rl            ctrl       ca ea      cs es
        tv[0]  = '{0, 0, 0, 0, 32'h0,  32'h0,  32'h0,        32'h1111,     32'b11000, 0, 32'h0,  0, 32'h0};
        tv[1]  = '{1, 0, 0, 0, 32'h40, 32'h0,  32'h0,        32'h2222,     32'b11000, 0, 32'h0,  0, 32'h0};
        tv[2]  = '{1, 0, 0, 0, 32'h40, 32'h0,  32'h0,        32'h3333,     32'b11100, 1, 32'h40, 0, 32'h0};
        tv[3]  = '{1, 0, 0, 0, 32'h40, 32'h0,  32'h0,        32'h4444,     32'b11100, 1, 32'h40, 0, 32'h0};
        tv[4]  = '{1, 0, 0, 1, 32'h40, 32'h0,  32'h0,        32'h1234ABCD, 32'b01100, 1, 32'h40, 0, 32'h0};
        tv[5]  = '{0, 0, 0, 0, 32'h0,  32'h0,  32'h0,        32'h5555,     32'b11000, 0, 32'h0,  0, 32'h0};
        tv[6]  = '{0, 0, 1, 0, 32'h0,  32'h80, 32'hDEADBEEF, 32'h6666,     32'b11000, 0, 32'h0,  0, 32'h0};
        tv[7]  = '{0, 0, 1, 1, 32'h0,  32'h80, 32'hDEADBEEF, 32'h7777,     32'b10010, 1, 32'h80, 1, 32'hDEADBEEF};
        tv[8]  = '{0, 0, 1, 0, 32'h0,  32'h80, 32'hDEADBEEF, 32'h8888,     32'b11000, 0, 32'h0,  0, 32'h0};
        tv[9]  = '{0, 0, 1, 0, 32'h0,  32'h80, 32'hDEADBEEF, 32'h9999,     32'b11010, 1, 32'h80, 1, 32'hDEADBEEF};
        tv[10] = '{0, 0, 0, 1, 32'h0,  32'h0,  32'h0,        32'hAAAA,     32'b11010, 1, 32'h80, 0, 32'h0};
        tv[11] = '{0, 0, 0, 0, 32'h0,  32'h0,  32'h0,        32'hBBBB,     32'b11000, 0, 32'h0,  0, 32'h0};
        tv[12] = '{0, 1, 1, 0, 32'h0,  32'h84, 32'h55,       32'hCCCC,     32'b11000, 0, 32'h0,  0, 32'h0};
        tv[13] = '{0, 1, 1, 1, 32'h0,  32'h84, 32'h55,       32'hDDDD,     32'b10010, 1, 32'h84, 1, 32'h55};
        tv[14] = '{0, 0, 0, 0, 32'h0,  32'h0,  32'h0,        32'hEEEE,     32'b11000, 0, 32'h0,  0, 32'h0};
    endtask

    // Simultaneous instruction and data reads; first_d says which side must win.
    task automatic tie(input bit first_d, input bit serve_second);
        iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h500; daddr = 32'h600; ramready = 0;
        @(negedge CLK); chk("tie_idle", ctrl(), 32'b11000); tick();
        ramready = 1;
        @(negedge CLK);
        chk("tie_first", ctrl(), first_d ? 32'b10100 : 32'b01100);
        chk("tie_first_addr", ramaddr, first_d ? 32'h600 : 32'h500);
        tick();
        ramready = 0;
        if (first_d) dREN = 0; else iREN = 0;
        if (!serve_second) begin iREN = 0; dREN = 0; end
        @(negedge CLK); chk("tie_bubble", ctrl(), 32'b11000); tick();
        if (serve_second) begin
            ramready = 1;
            @(negedge CLK);
            chk("tie_second", ctrl(), first_d ? 32'b01100 : 32'b10100);
            chk("tie_second_addr", ramaddr, first_d ? 32'h500 : 32'h600);
            tick();
            iREN = 0; dREN = 0; ramready = 0;
            @(negedge CLK); chk("tie_done", ctrl(), 32'b11000); tick();
        end
    endtask

    initial begin
        bit i_on, d_on;
        nRST = 0;
        clear_inputs();
        do_reset();

        fill_table();
        for (int i = 0; i < 15; i++) begin
            iREN = tv[i].iren; dREN = tv[i].dren; dWEN = tv[i].dwen; ramready = tv[i].rr;
            iaddr = tv[i].ia; daddr = tv[i].da; dstore = tv[i].ds; ramload = tv[i].rl;
            @(negedge CLK);
            chk($sformatf("vec%0d_ctrl", i), ctrl(), tv[i].ectrl);
            if (tv[i].ca) chk($sformatf("vec%0d_addr", i), ramaddr, tv[i].ea);
            if (tv[i].cs) chk($sformatf("vec%0d_store", i), ramstore, tv[i].es);
            chk($sformatf("vec%0d_iload", i), iload, tv[i].rl);
            chk($sformatf("vec%0d_dload", i), dload, tv[i].rl);
            tick();
        end
        clear_inputs();
        tick();

`ifdef MEMORY_ARBITER_RR_EN
        tie(0, 0);
        tie(1, 1);
`else
        tie(1, 1);
        tie(1, 0);
`endif

        // Data read withdrawn mid-grant: late ramready must not complete it.
        dREN = 1; daddr = 32'h300;
        @(negedge CLK); chk("drop_idle", ctrl(), 32'b11000); tick();
        @(negedge CLK); chk("drop_grant", ctrl(), 32'b11100); tick();
        dREN = 0; ramready = 1;
        @(negedge CLK); chk("drop_no_pulse", ctrl(), 32'b11100); tick();
        @(negedge CLK); chk("drop_back_idle", ctrl(), 32'b11000); tick();
        ramready = 0;

        // Reset in the middle of a grant.
        iREN = 1; iaddr = 32'h100;
        tick();
        @(negedge CLK); chk("rst_mid_grant", ctrl(), 32'b11100); tick();
        nRST = 0;
        #1;
        chk("rst_async_ctrl", ctrl(), 32'b11000);
        chk("rst_async_addr", ramaddr, 32'h0);
        tick();
        nRST = 1; ramready = 1;
        @(negedge CLK); chk("rst_no_completion", ctrl(), 32'b11000); tick();
        clear_inputs();
        tick();

        // Timeout: 255 grant cycles without ramready.
        iREN = 1; iaddr = 32'h200;
        @(negedge CLK); chk("to_idle", ctrl(), 32'b11000); tick();
        for (int k = 0; k < 255; k++) begin
            @(negedge CLK);
            if (k == 0 || k == 254) chk($sformatf("to_grant_%0d", k), ctrl(), 32'b11100);
            tick();
        end
        iREN = 0;
        @(negedge CLK); chk("to_expired", ctrl(), 32'b11001); tick();
        repeat (4) tick();
        iREN = 1; iaddr = 32'h204;
        tick();
        ramready = 1;
        @(negedge CLK); chk("to_err_sticky", ctrl(), 32'b01101); tick();
        clear_inputs();
        @(negedge CLK); chk("to_err_hold", ctrl(), 32'b11001); tick();
        do_reset();

        // Randomized traffic against the reference model.
        model_reset();
        i_on = 0; d_on = 0;
        for (int c = 0; c < 3000; c++) begin
            if (i_on && (!e_iwait || $urandom_range(49) == 0)) begin
                i_on = 0; iREN = 0;
            end else if (!i_on && $urandom_range(2) == 0) begin
                i_on = 1; iREN = 1; iaddr = $urandom;
            end
            if (d_on && (!e_dwait || $urandom_range(49) == 0)) begin
                d_on = 0; dREN = 0; dWEN = 0;
            end else if (!d_on && $urandom_range(2) == 0) begin
                d_on = 1; daddr = $urandom; dstore = $urandom;
                case ($urandom_range(2))
                    0:       begin dREN = 1; dWEN = 0; end
                    1:       begin dREN = 0; dWEN = 1; end
                    default: begin dREN = 1; dWEN = 1; end
                endcase
            end
            ramready = ($urandom_range(2) == 0);
            ramload  = $urandom;
            @(negedge CLK);
            model_expect();
            chk("rand_ctrl", ctrl(), {27'd0, e_iwait, e_dwait, e_ren, e_wen, m_err});
            if (m_side != 0) chk("rand_addr", ramaddr, m_addr);
            if (m_side == 2 && m_wr) chk("rand_store", ramstore, m_store);
            chk("rand_load", {iload ^ ramload} | {dload ^ ramload}, 32'h0);
            tick();
            model_advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
